alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 5-bit operation code produced by the ALU control decoder, plus two operands and a shift amount.
- Produces a registered result with zero/overflow flags under a valid/ready handshake on both sides.
- Logical and arithmetic ops complete in one cycle. Shifts run iteratively, one bit per cycle, so the block has real multi-cycle occupancy and back-pressure into the pipeline.

---
 rtl/alu_exec_unit.sv | 192 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// alu_exec_unit -- execute-stage ALU with a valid/ready handshake on both sides.
//
// Consumes the 5-bit ALU control code plus two operands and a shift amount.
// It produces a registered result with zero/overflow/illegal flags.
// Logical and arithmetic ops complete one cycle after accept.
// sll/srl run iteratively, one bit per cycle, so latency is shamt+1.
// Define BARREL_SHIFT_EN to shift combinationally instead; every op then
// completes in one cycle, and the SHIFT state and counter are not built.
//
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   in_valid / in_ready   request handshake (in_ready is combinational)
//   operation             5-bit op code (0x00..0x0B legal)
//   src_a, src_b, shamt   operands and shift amount, captured on accept
//   out_valid / out_ready result handshake
//   result, zero,         registered result and flags, held while
//   overflow, illegal_op  out_valid is high
//   busy                  unit is not idle
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [4:0]         operation,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal_op,
  output logic               busy
);

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_LUI  = 5'h01;
  localparam logic [4:0] OP_OR   = 5'h02;
  localparam logic [4:0] OP_ADD  = 5'h03;
  localparam logic [4:0] OP_AND  = 5'h04;
  localparam logic [4:0] OP_SUB  = 5'h05;
  localparam logic [4:0] OP_SLL  = 5'h06;
  localparam logic [4:0] OP_SRL  = 5'h07;
  localparam logic [4:0] OP_SLT  = 5'h08;
  localparam logic [4:0] OP_SLTU = 5'h09;
  localparam logic [4:0] OP_NOR  = 5'h0A;
  localparam logic [4:0] OP_JR   = 5'h0B;

`ifdef BARREL_SHIFT_EN
  typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;
  logic               ill_q, ill_d;
`ifndef BARREL_SHIFT_EN
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               dir_q, dir_d;      // 1: shift right (srl)
  logic [WIDTH-1:0]   shifted;
`endif

  logic               accept;
  logic [WIDTH-1:0]   sum, diff, alu_res;
  logic               alu_ovf, alu_ill;

  // Single-cycle datapath, evaluated on the live inputs. It is used only on accept.
  always_comb begin
    sum     = src_a + src_b;
    diff    = src_a - src_b;
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (operation)
      OP_NOP:  alu_res = '0;
      OP_LUI:  alu_res = src_b << (WIDTH / 2);
      OP_OR:   alu_res = src_a | src_b;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
      end
      OP_AND:  alu_res = src_a & src_b;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
      end
`ifdef BARREL_SHIFT_EN
      OP_SLL:  alu_res = src_b << shamt;
      OP_SRL:  alu_res = src_b >> shamt;
`else
      // The iterative build only takes this path when shamt == 0.
      OP_SLL, OP_SRL: alu_res = src_b;
`endif
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, src_a < src_b};
      OP_NOR:  alu_res = ~(src_a | src_b);
      OP_JR:   alu_res = src_a;
      default: alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
`ifndef BARREL_SHIFT_EN
    count_d  = count_q;
    dir_d    = dir_q;
    shifted  = dir_q ? (result_q >> 1) : (result_q << 1);
`endif

    in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept   = in_valid && in_ready;

    case (state_q)
`ifndef BARREL_SHIFT_EN
      // result_q doubles as the shift register while the shift is in flight.
      SHIFT: begin
        result_d = shifted;
        count_d  = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = DONE;
          zero_d  = (shifted == '0);
        end
      end
`endif
      DONE:    if (out_ready && !in_valid) state_d = IDLE;
      default: ;
    endcase

    // An accept from DONE overrides the return to IDLE, which gives back-to-back issue.
    if (accept) begin
      ovf_d = alu_ovf;
      ill_d = alu_ill;
`ifndef BARREL_SHIFT_EN
      if ((operation == OP_SLL || operation == OP_SRL) && shamt != '0) begin
        result_d = src_b;
        zero_d   = 1'b0;
        count_d  = shamt;
        dir_d    = (operation == OP_SRL);
        state_d  = SHIFT;
      end else
`endif
      begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        state_d  = DONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
`ifndef BARREL_SHIFT_EN
      count_q  <= '0;
      dir_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
`ifndef BARREL_SHIFT_EN
      count_q  <= count_d;
      dir_q    <= dir_d;
`endif
    end
  end

  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign result     = result_q;
  assign zero       = zero_q;
  assign overflow   = ovf_q;
  assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit. Directed scenarios plus a randomized sweep are
// checked against a plain-arithmetic reference model. Honours BARREL_SHIFT_EN.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  operation = '0;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [4:0]  shamt = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero, overflow, illegal_op, busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .src_a(src_a), .src_b(src_b), .shamt(shamt),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_result(input int op, input logic [31:0] a,
                                             input logic [31:0] b, input int sh);
    case (op)
      0:  return 32'd0;
      1:  return b * 32'h10000;
      2:  return a | b;
      3:  return a + b;
      4:  return a & b;
      5:  return a - b;
      6:  return b << sh;
      7:  return b >> sh;
      8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      9:  return (a < b) ? 32'd1 : 32'd0;
      10: return ~(a | b);
      11: return a;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_ovf(input int op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == 3)      s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 5) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  function automatic int ref_lat(input int op, input int sh);
`ifdef BARREL_SHIFT_EN
    return 1;
`else
    return ((op == 6 || op == 7) && sh != 0) ? sh + 1 : 1;
`endif
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  // Drives one request while the unit is ready. Afterwards the inputs are
  // scrambled, so only the values captured on accept may matter.
  task automatic send(input int op, input logic [31:0] a, input logic [31:0] b, input int sh);
    in_valid  = 1'b1;
    operation = 5'(op);
    src_a     = a;
    src_b     = b;
    shamt     = 5'(sh);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    operation = 5'($urandom);
    src_a     = $urandom;
    src_b     = $urandom;
    shamt     = 5'($urandom);
  endtask

  // Counts cycles from accept until out_valid, bounded at 100.
  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input int sh,
                        output int lat, output logic [31:0] r, output logic z,
                        output logic o, output logic il);
    send(op, a, b, sh);
    wait_out(lat);
    r = result; z = zero; o = overflow; il = illegal_op;
    release_out();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, busy, zero, overflow, illegal_op, in_ready} !== 6'b000001 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL reset: ov/busy/z/ovf/ill/rdy=%b result=%h, expected 000001 / 0",
               {out_valid, busy, zero, overflow, illegal_op, in_ready}, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add_overflow();
    int lat; logic [31:0] r; logic z, o, il;
    run_op(3, 32'h7FFFFFFF, 32'h00000001, 0, lat, r, z, o, il);
    n_checks++;
    if (lat !== 1 || r !== 32'h80000000 || o !== 1'b1 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL add_overflow: lat=%0d r=%h ovf=%b z=%b, expected 1 80000000 1 0", lat, r, o, z);
    end
  endtask

  task automatic test_sub_zero();
    int lat; logic [31:0] r; logic z, o, il;
    run_op(5, 32'h1234, 32'h1234, 0, lat, r, z, o, il);
    n_checks++;
    if (lat !== 1 || r !== 32'd0 || z !== 1'b1 || o !== 1'b0) begin
      n_fail++;
      $display("FAIL sub_zero: lat=%0d r=%h z=%b ovf=%b, expected 1 0 1 0", lat, r, z, o);
    end
  endtask

  task automatic test_sll_long();
    int bad = 0;
    send(6, 32'h0, 32'h00000001, 31);
`ifndef BARREL_SHIFT_EN
    for (int i = 0; i < 31; i++) begin
      if (!busy || in_ready || out_valid) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL sll_occupancy: %0d cycles not busy/blocked, expected 0", bad);
    end
`endif
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'h80000000 || zero !== 1'b0) begin
      n_fail++;
      $display("FAIL sll_result: ov=%b r=%h z=%b, expected 1 80000000 0", out_valid, result, zero);
    end
    release_out();
  endtask

  task automatic test_lui_slt();
    int lat; logic [31:0] r; logic z, o, il;
    run_op(1, 32'h0, 32'h0000ABCD, 0, lat, r, z, o, il);
    n_checks++;
    if (r !== 32'hABCD0000) begin
      n_fail++;
      $display("FAIL lui: r=%h, expected abcd0000", r);
    end
    run_op(8, 32'hFFFFFFFF, 32'h1, 0, lat, r, z, o, il);
    n_checks++;
    if (r !== 32'd1 || z !== 1'b0) begin
      n_fail++;
      $display("FAIL slt: r=%h z=%b, expected 1 0", r, z);
    end
    run_op(9, 32'hFFFFFFFF, 32'h1, 0, lat, r, z, o, il);
    n_checks++;
    if (r !== 32'd0 || z !== 1'b1) begin
      n_fail++;
      $display("FAIL sltu: r=%h z=%b, expected 0 1", r, z);
    end
  endtask

  task automatic test_back_to_back();
    int lat; int bad = 0;
    send(3, 32'd5, 32'd6, 0);
    wait_out(lat);
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || in_ready || result !== 32'd11 || zero || overflow || illegal_op) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL hold: %0d unstable cycles, expected 0 (result=%h)", bad, result);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    operation = 5'h02;
    src_a     = 32'h000000F0;
    src_b     = 32'h0000000F;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: in_ready=%b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || result !== 32'h000000FF) begin
      n_fail++;
      $display("FAIL b2b_result: ov=%b r=%h, expected 1 000000ff", out_valid, result);
    end
    release_out();
  endtask

  task automatic test_reset_midshift();
    int seen = 0;
    send(7, 32'h0, 32'hFFFF0000, 10);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, busy, zero, overflow, illegal_op} !== 5'b0 || result !== 32'd0) begin
      n_fail++;
      $display("FAIL midshift_reset: ov/busy/z/ovf/ill=%b r=%h, expected 00000 0",
               {out_valid, busy, zero, overflow, illegal_op}, result);
    end
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL midshift_discard: out_valid seen %0d times, expected 0", seen);
    end
  endtask

  task automatic test_illegal();
    int lat; logic [31:0] r; logic z, o, il;
    run_op(31, 32'hDEADBEEF, 32'h12345678, 3, lat, r, z, o, il);
    n_checks++;
    if (il !== 1'b1 || r !== 32'd0 || z !== 1'b1 || lat !== 1) begin
      n_fail++;
      $display("FAIL illegal: ill=%b r=%h z=%b lat=%0d, expected 1 0 1 1", il, r, z, lat);
    end
    run_op(11, 32'hCAFE0001, 32'h0, 0, lat, r, z, o, il);
    n_checks++;
    if (il !== 1'b0 || r !== 32'hCAFE0001) begin
      n_fail++;
      $display("FAIL illegal_clear: ill=%b r=%h, expected 0 cafe0001", il, r);
    end
  endtask

  task automatic test_random();
    int lat, op, sh;
    logic [31:0] a, b, r, er;
    logic z, o, il;
    for (int i = 0; i < 60; i++) begin
      op = (i % 3 == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 11));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = {a[31], 31'h7FFFFFF0};
      sh = (i % 7 == 0) ? 0 : int'($urandom_range(0, 31));
      run_op(op, a, b, sh, lat, r, z, o, il);
      er = ref_result(op, a, b, sh);
      n_checks++;
      if (r !== er || z !== (er == 32'd0) || o !== ref_ovf(op, a, b) ||
          il !== (op >= 12) || lat != ref_lat(op, sh)) begin
        n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h sh=%0d: got r=%h z=%b o=%b il=%b lat=%0d, want r=%h z=%b o=%b il=%b lat=%0d",
                 i, op, a, b, sh, r, z, o, il, lat, er, (er == 32'd0), ref_ovf(op, a, b), (op >= 12),
                 ref_lat(op, sh));
      end
    end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_zero();
    test_sll_long();
    test_lui_slt();
    test_back_to_back();
    test_reset_midshift();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
